// File: rtl/qarctan_seq.sv
// Sequential quantized arctan(y/x): one sample at a time through a
// bit-serial restoring divider followed by a single constant multiply.
module qarctan_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10,
    parameter int QUAD1      = 804
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [W-1:0] QUAD1_V = W'(QUAD1);
    localparam logic [W-1:0] QUAD3_V = W'(3 * QUAD1);
    localparam logic signed [2*W-1:0] BIAS = (2*W)'((1 << FRAC_BITS) - 1);

    typedef enum logic [2:0] {IDLE, PREP, DIV, MUL, HOLD} state_t;

    state_t state_reg, state_next;

    logic [W-1:0]  x_reg, y_reg;
    logic [W-1:0]  rem_reg, quo_reg, den_mag_reg;
    logic          neg_reg, den_zero_reg, ready_en_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  data_out_reg;
    logic          accept;

    // Operand preparation from the captured sample
    logic [W-1:0] abs_y, diff, num, den, num_mag, den_mag;
    assign abs_y   = (y_reg[W-1] ? -y_reg : y_reg) + W'(1);
    assign diff    = x_reg[W-1] ? (x_reg + abs_y) : (x_reg - abs_y);
    assign num     = diff << FRAC_BITS;
    assign den     = x_reg[W-1] ? (abs_y - x_reg) : (x_reg + abs_y);
    assign num_mag = num[W-1] ? -num : num;
    assign den_mag = den[W-1] ? -den : den;

    // One restoring-division step; the dividend shifts out of quo_reg as
    // quotient bits shift in.
    logic [W:0]   rem_shift;
    logic         fits;
    logic [W-1:0] rem_step;
    assign rem_shift = {rem_reg, quo_reg[W-1]};
    assign fits      = rem_shift >= {1'b0, den_mag_reg};
    assign rem_step  = fits ? W'(rem_shift - {1'b0, den_mag_reg}) : rem_shift[W-1:0];

    // Multiply by pi/4 and rescale, rounding the quotient toward zero
    logic [W-1:0]          r_val, d_val, angle, result;
    logic signed [2*W-1:0] q1_ext, r_ext, prod, prod_adj;
    assign r_val    = den_zero_reg ? '0 : (neg_reg ? -quo_reg : quo_reg);
    assign q1_ext   = {{W{QUAD1_V[W-1]}}, QUAD1_V};
    assign r_ext    = {{W{r_val[W-1]}}, r_val};
    assign prod     = q1_ext * r_ext;
    assign prod_adj = prod[2*W-1] ? (prod + BIAS) : prod;
    assign d_val    = W'(prod_adj >>> FRAC_BITS);
    assign angle    = (x_reg[W-1] ? QUAD3_V : QUAD1_V) - d_val;
    assign result   = y_reg[W-1] ? -angle : angle;

    assign accept   = in_valid && in_ready;
    assign data_out = data_out_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = ready_en_reg;
                if (in_valid && ready_en_reg) state_next = PREP;
            end
            PREP: state_next = DIV;
            DIV:  if (cnt_reg == CW'(W - 1)) state_next = MUL;
            MUL:  state_next = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_reg        <= '0;
            y_reg        <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            den_mag_reg  <= '0;
            neg_reg      <= 1'b0;
            den_zero_reg <= 1'b0;
            ready_en_reg <= 1'b0;
            cnt_reg      <= '0;
            data_out_reg <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        x_reg <= x;
                        y_reg <= y;
                    end
                end
                PREP: begin
                    quo_reg      <= num_mag;
                    den_mag_reg  <= den_mag;
                    rem_reg      <= '0;
                    neg_reg      <= num[W-1] ^ den[W-1];
                    den_zero_reg <= (den == '0);
                    cnt_reg      <= '0;
                end
                DIV: begin
                    rem_reg <= rem_step;
                    quo_reg <= {quo_reg[W-2:0], fits};
                    cnt_reg <= cnt_reg + CW'(1);
                end
                MUL: data_out_reg <= result;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_qarctan_seq.sv
// Bench for qarctan_seq: a 32-bit/10-frac instance and a 16-bit/8-frac
// instance checked against an integer arctan model.
module tb_qarctan_seq;
    localparam int AW = 32, AF = 10, AQ = 804;
    localparam int BW = 16, BF = 8,  BQ = 201;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [AW-1:0] a_x, a_y, a_data_out;
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [BW-1:0] b_x, b_y, b_data_out;

    qarctan_seq #(.DATA_WIDTH(AW), .FRAC_BITS(AF), .QUAD1(AQ)) dut_a (
        .clk(clk), .reset(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .x(a_x), .y(a_y), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .data_out(a_data_out));

    qarctan_seq #(.DATA_WIDTH(BW), .FRAC_BITS(BF), .QUAD1(BQ)) dut_b (
        .clk(clk), .reset(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .x(b_x), .y(b_y), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .data_out(b_data_out));

    int     n_checks = 0, n_fail = 0;
    longint cyc = 0;
    longint qa_exp[$], qa_acc[$], qb_exp[$], qb_acc[$];
    bit     prev_ov[2], consumed[2];
    int     mode_a = 0, mode_b = 0;  // 0 always ready, 1 random, 2 stalled

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint wrapw(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint qm(input longint x, input longint y, input int w,
                                  input int f, input longint q1);
        longint ay, num, den, r, d, angle;
        ay = wrapw(((y < 0) ? -y : y) + 1, w);
        if (x >= 0) begin
            num = wrapw(wrapw(x - ay, w) <<< f, w);
            den = wrapw(x + ay, w);
        end else begin
            num = wrapw(wrapw(x + ay, w) <<< f, w);
            den = wrapw(ay - x, w);
        end
        r     = (den == 0) ? 0 : wrapw(num / den, w);
        d     = wrapw((q1 * r) / (64'sd1 <<< f), w);
        angle = wrapw(((x >= 0) ? q1 : 3 * q1) - d, w);
        return (y < 0) ? wrapw(-angle, w) : angle;
    endfunction

    function automatic longint pick(input int w);
        case ($urandom_range(0, 7))
            0: return -(64'sd1 <<< (w - 1));
            1: return (64'sd1 <<< (w - 1)) - 1;
            2: return 0;
            3: return -1;
            4: return longint'($urandom_range(0, 4000)) - 2000;
            default: return wrapw(longint'($urandom), w);
        endcase
    endfunction

    // Cycle 1 is the cycle following the accepting edge.
    task automatic cmp(input int id, input logic ov, input logic ir, input logic ordy,
                       input longint dout, input int w);
        longint exp_v, acc_v;
        int     qsize;
        qsize = (id == 0) ? qa_exp.size() : qb_exp.size();
        if (consumed[id]) begin
            check($sformatf("dut%0d_valid_after_consume", id), longint'(ov), 0);
            check($sformatf("dut%0d_ready_after_consume", id), longint'(ir), 1);
        end
        if (ov) begin
            if (qsize == 0) begin
                check($sformatf("dut%0d_unexpected_out_valid", id), longint'(ov), 0);
            end else begin
                exp_v = (id == 0) ? qa_exp[0] : qb_exp[0];
                acc_v = (id == 0) ? qa_acc[0] : qb_acc[0];
                check($sformatf("dut%0d_data_out", id), dout, exp_v);
                check($sformatf("dut%0d_in_ready_in_hold", id), longint'(ir), 0);
                if (!prev_ov[id])
                    check($sformatf("dut%0d_latency", id), cyc - acc_v + 1, w + 3);
            end
        end
        consumed[id] = ov && ordy && (qsize != 0);
        if (consumed[id]) begin
            if (id == 0) begin void'(qa_exp.pop_front()); void'(qa_acc.pop_front()); end
            else begin void'(qb_exp.pop_front()); void'(qb_acc.pop_front()); end
        end
        prev_ov[id] = ov;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmp(0, a_out_valid, a_in_ready, a_out_ready, longint'($signed(a_data_out)), AW);
            cmp(1, b_out_valid, b_in_ready, b_out_ready, longint'($signed(b_data_out)), BW);
        end
    end

    initial forever begin
        @(posedge clk);
        #3;
        a_out_ready = (mode_a == 0) ? 1'b1 : (mode_a == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        b_out_ready = (mode_b == 0) ? 1'b1 : (mode_b == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic send(input int id, input longint xv, input longint yv, input bit noise);
        int     t;
        longint xw, yw;
        logic   rdy;
        xw = wrapw(xv, (id == 0) ? AW : BW);
        yw = wrapw(yv, (id == 0) ? AW : BW);
        @(posedge clk);
        #2;
        if (id == 0) begin a_x = xw[AW-1:0]; a_y = yw[AW-1:0]; a_in_valid = 1'b1; end
        else begin b_x = xw[BW-1:0]; b_y = yw[BW-1:0]; b_in_valid = 1'b1; end
        t = 0;
        rdy = (id == 0) ? a_in_ready : b_in_ready;
        while (rdy !== 1'b1 && t < 300) begin
            @(posedge clk);
            #2;
            t++;
            rdy = (id == 0) ? a_in_ready : b_in_ready;
        end
        if (rdy !== 1'b1) begin
            check($sformatf("dut%0d_accept_timeout_in_ready", id), longint'(rdy), 1);
        end else if (id == 0) begin
            qa_exp.push_back(qm(xw, yw, AW, AF, AQ));
            qa_acc.push_back(cyc + 1);
        end else begin
            qb_exp.push_back(qm(xw, yw, BW, BF, BQ));
            qb_acc.push_back(cyc + 1);
        end
        @(posedge clk);
        #2;
        if (noise) begin
            repeat (12) begin
                if (id == 0) begin a_x = $urandom; a_y = $urandom; end
                else begin b_x = BW'($urandom); b_y = BW'($urandom); end
                @(posedge clk);
                #2;
            end
        end
        if (id == 0) a_in_valid = 1'b0; else b_in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((qa_exp.size() + qb_exp.size()) != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check("drain_outstanding", longint'(qa_exp.size() + qb_exp.size()), 0);
    endtask

    longint dax[10] = '{1024, 0, 0, -1024, 1024, -64'sd2147483648, 64'sd2147483647,
                        -64'sd2147483648, -1, 500};
    longint day[10] = '{0, 1024, -1024, 0, 1024, 0, -64'sd2147483648,
                        -64'sd2147483648, -1, -300};
    longint dbx[5]  = '{256, -32768, 32767, -100, 1000};
    longint dby[5]  = '{0, -32768, -32768, 77, -2000};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_x = '0; a_y = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_x = '0; b_y = '0; b_out_ready = 1'b1;

        check("model_1024_0", qm(1024, 0, AW, AF, AQ), 2);
        check("model_0_1024", qm(0, 1024, AW, AF, AQ), 1608);
        check("model_0_m1024", qm(0, -1024, AW, AF, AQ), -1608);
        check("model_m1024_0", qm(-1024, 0, AW, AF, AQ), 3214);
        check("model_1024_1024", qm(1024, 1024, AW, AF, AQ), 804);
        check("model_xmin_0", qm(-64'sd2147483648, 0, AW, AF, AQ), 2412);
        check("model_den_zero", qm(64'sd2147483647, -64'sd2147483648, AW, AF, AQ), -804);
        check("model16_256_0", qm(256, 0, BW, BF, BQ), 201);

        repeat (3) @(posedge clk);
        #2;
        check("reset_in_ready", longint'(a_in_ready), 0);
        check("reset_out_valid", longint'(a_out_valid), 0);
        check("reset_data_out", longint'(a_data_out), 0);
        rst_n = 1'b1;
        #1;
        check("release_in_ready_before_edge", longint'(a_in_ready), 0);
        @(posedge clk);
        #2;
        check("release_in_ready_after_edge", longint'(a_in_ready), 1);
        check("release_b_in_ready_after_edge", longint'(b_in_ready), 1);

        for (int i = 0; i < 10; i++) begin
            send(0, dax[i], day[i], i == 9);
            drain();
        end
        for (int i = 0; i < 5; i++) begin
            send(1, dbx[i], dby[i], i == 4);
            drain();
        end

        // Back-pressure: hold the result for ten cycles, then release
        mode_a = 2;
        send(0, 1024, 0, 1'b0);
        for (int t = 0; t < 100 && a_out_valid !== 1'b1; t++) begin
            @(posedge clk);
            #2;
        end
        repeat (10) @(posedge clk);
        #2;
        check("stall_out_valid", longint'(a_out_valid), 1);
        check("stall_data_out", longint'($signed(a_data_out)), 2);
        check("stall_in_ready", longint'(a_in_ready), 0);
        mode_a = 0;
        drain();

        // Reset in the middle of the divide discards the sample
        send(0, 1024, 1024, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("middiv_reset_out_valid", longint'(a_out_valid), 0);
        check("middiv_reset_data_out", longint'(a_data_out), 0);
        check("middiv_reset_in_ready", longint'(a_in_ready), 0);
        qa_exp.delete(); qa_acc.delete();
        prev_ov = '{default: 1'b0};
        consumed = '{default: 1'b0};
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        send(0, 1024, 0, 1'b0);
        drain();

        mode_a = 1;
        mode_b = 1;
        fork
            for (int i = 0; i < 100; i++) send(0, pick(AW), pick(AW), 1'b0);
            for (int j = 0; j < 200; j++) send(1, pick(BW), pick(BW), 1'b0);
        join
        drain();
        mode_a = 0;
        mode_b = 0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/qarctan_seq.md
QARCTAN_SEQ -- requirements
Module: qarctan_seq

Interface
REQ-001 SHALL expose parameter DATA_WIDTH, default 32, meaning width of x, y and data_out (two's complement).
REQ-002 SHALL expose parameter FRAC_BITS, default 10, meaning fixed-point fraction bits (QUANTIZE scale 2^FRAC_BITS).
REQ-003 SHALL expose parameter QUAD1, default 804, meaning QUANTIZE(pi/4) at FRAC_BITS; QUAD3 SHALL be derived internally as 3*QUAD1 (2412 at defaults).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, meaning x/y present.
REQ-007 SHALL have port in_ready, output, 1, meaning block accepts a sample this cycle.
REQ-008 SHALL have ports x and y, input, DATA_WIDTH each, meaning signed quantized I and Q.
REQ-009 SHALL have port out_valid, output, 1, meaning data_out holds a result.
REQ-010 SHALL have port out_ready, input, 1, meaning downstream consumes data_out.
REQ-011 SHALL have port data_out, output, DATA_WIDTH, meaning signed quantized angle in [-pi, pi].

Function
REQ-012 SHALL accept a sample only when in_valid and in_ready are both 1; x and y SHALL be registered on that edge.
REQ-013 SHALL implement FSM states IDLE, PREP, DIV, MUL, HOLD; in_ready = 1 only in IDLE; out_valid = 1 only in HOLD.
REQ-014 IDLE -> PREP on accept; PREP -> DIV after 1 cycle; DIV -> MUL after exactly DATA_WIDTH cycles; MUL -> HOLD after 1 cycle; HOLD -> IDLE on out_ready = 1, else stay in HOLD with data_out stable.
REQ-015 Latency: out_valid SHALL assert exactly DATA_WIDTH+3 cycles after the accepting edge (35 at defaults); throughput one sample per DATA_WIDTH+4 cycles when out_ready is held 1.
REQ-016 PREP: abs_y = |y| + 1, computed in DATA_WIDTH bits with wrap; if x >= 0: num = (x - abs_y) << FRAC_BITS, den = x + abs_y; else num = (x + abs_y) << FRAC_BITS, den = abs_y - x; all DATA_WIDTH-bit wrapping arithmetic.
REQ-017 DIV: restoring divider on magnitudes, one quotient bit per cycle; r = num / den truncated toward zero, sign = sign(num) XOR sign(den).
REQ-018 den = 0 (only reachable via wrap) SHALL yield r = 0 without stalling or changing cycle count.
REQ-019 MUL: p = QUAD1 * r as 2*DATA_WIDTH-bit signed product; d = p / 2^FRAC_BITS truncated toward zero (not arithmetic shift), then truncated to DATA_WIDTH.
REQ-020 angle = QUAD1 - d if x >= 0, else QUAD3 - d; data_out = -angle if y < 0, else angle.
REQ-021 Results SHALL be bit-exact against the integer C model of qarctan using the same DATA_WIDTH wrap rules.
REQ-022 in_valid while not in IDLE SHALL be ignored; the held sample SHALL be unaffected.
REQ-023 out_ready while not in HOLD SHALL have no effect.

Reset
REQ-024 reset = 0 SHALL asynchronously force state IDLE, in_ready = 0 while asserted, out_valid = 0, data_out = 0 and clear all datapath registers.
REQ-025 in_ready SHALL go 1 on the first clock edge after reset deasserts; reset during DIV or HOLD SHALL discard the sample with no output produced.

Verification
REQ-026 x=1024, y=0 -> data_out = 2, out_valid on cycle 35 after accept.
REQ-027 x=0, y=1024 -> 1608; x=0, y=-1024 -> -1608.
REQ-028 x=-1024, y=0 -> 3214; x=1024, y=1024 -> 804.
REQ-029 Back-pressure: out_ready=0 for 10 cycles after out_valid -> data_out and out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-030 Assert reset mid-DIV (cycle 10) -> out_valid=0, data_out=0 immediately; after release, new sample x=1024, y=0 -> 2 at standard latency.
REQ-031 Random 10k samples incl. x/y = most-negative value, DATA_WIDTH=16/FRAC_BITS=8 variant -> bit-exact vs C model.
